act_reg_read_responder: RTL and testbench
=========================================

// Module: act_reg_read_responder
// PURPOSE
//  Register-file side of the activation byte-stream read protocol (vegeta_reg read port).
//  Holds NUM_REGS activation tiles, each ROWS x ROW_BYTES bytes.
//  Serves one read request at a time by streaming one byte per cycle, with row_last and reg_last framing.
//  Accepts byte writes from the loader; a write to the tile currently being streamed is back-pressured.
// PARAMETERS
//  NUM_REGS   8  number of tiles; address width $clog2(NUM_REGS)
//  ROWS       4  rows per tile (power of 2, >=2)
//  ROW_BYTES  8  bytes per row (power of 2, >=2)
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous active-high reset
//  read_req      in   1        level request from reader
//  read_mode     in   2        00 full row-major, 01 upper half rows, 10 column-major, 11 = treated as 00
//  read_address  in   AW       tile index, AW = $clog2(NUM_REGS)
//  read_data     out  8        streamed byte
//  read_valid    out  1        read_data valid this cycle
//  row_last      out  1        last byte of current row (or column in mode 10)
//  reg_last      out  1        last byte of the transfer
//  busy          out  1        request accepted and not yet complete
//  wr_en         in   1        byte write strobe
//  wr_addr       in   AW       tile index
//  wr_row        in   $clog2(ROWS)       row index
//  wr_col        in   $clog2(ROW_BYTES)  byte index within row
//  wr_data       in   8        write byte
//  wr_ready      out  1        write accepted when wr_en && wr_ready
// BEHAVIOUR
//  Reset: read_data=0, read_valid=0, row_last=0, reg_last=0, busy=0, wr_ready=1, FSM=IDLE, counters=0.
//   Tile storage is not cleared. Reset mid-stream aborts the stream immediately; no reg_last is emitted.
//  FSM states: IDLE, STREAM, WAIT_LOW.
//   IDLE -> STREAM when read_req=1; latch read_mode and read_address, clear row/col counters, busy<=1.
//   STREAM issues one synchronous storage read per cycle. Registered output gives 1-cycle read latency.
//   STREAM -> WAIT_LOW after issuing the last address.
//   WAIT_LOW -> IDLE once read_req=0 and the final byte has been output.
//    Re-arm therefore requires read_req low for >=1 cycle. A held read_req never restarts a stream.
//  Latency: read_req sampled at edge N (IDLE) -> first byte with read_valid=1 after edge N+2.
//   Bytes are then contiguous, one per cycle, with no gaps.
//  Byte count: mode 00/11 = ROWS*ROW_BYTES; mode 01 = (ROWS/2)*ROW_BYTES; mode 10 = ROWS*ROW_BYTES.
//  Ordering:
//   mode 00: rows 0..ROWS-1, bytes 0..ROW_BYTES-1.
//   mode 01: rows ROWS/2..ROWS-1, row-major.
//   mode 10: col 0..ROW_BYTES-1, rows 0..ROWS-1 within each column.
//  row_last: 1 with the last byte of each row (modes 00/01/11) or of each column (mode 10).
//  reg_last: 1 only with the final byte, coincident with row_last.
//  Framing outputs are single-cycle pulses, qualified by read_valid. read_data holds its last value when read_valid=0.
//  busy: 1 from the cycle after acceptance through the cycle carrying reg_last.
//  Writes: storage updates at the edge where wr_en && wr_ready.
//   wr_ready=0 while busy=1 and wr_addr == latched read_address; otherwise 1. wr_ready is combinational.
//   A blocked write is dropped and must be held by the writer.
//   A write to a different tile while streaming is accepted the same cycle.
//  read_address/read_mode changes after acceptance are ignored until the next IDLE acceptance.
//  Counters wrap at ROWS / ROW_BYTES. There is no other wrap-around; the transfer ends at reg_last.
// TESTING
//  1. Fill tile 3 with byte = 8*row+col; read mode 00:
//     32 bytes 0x00..0x1F, row_last on 0x07/0x0F/0x17/0x1F, reg_last on 0x1F only.
//  2. Same tile, mode 10:
//     order 0x00,0x08,0x10,0x18,0x01,...; row_last every 4th byte; reg_last on 0x1F.
//     Mode 01: 16 bytes 0x10..0x1F.
//  3. Hold read_req high for 60 cycles:
//     exactly one 32-byte stream; then pulse read_req low 1 cycle -> second stream starts 2 cycles after re-sample.
//  4. During a tile-3 stream, wr_en to tile 3:
//     wr_ready=0, storage unchanged, streamed bytes unchanged.
//     Concurrent write to tile 5: wr_ready=1, readback of tile 5 shows the new byte.
//  5. Assert rst at byte 10 of a stream:
//     the next cycle shows read_valid=0, busy=0, and no reg_last.
//     A new request after reset streams from byte 0; storage is intact.
//  6. Mode 11: identical output to mode 00.
//     read_address changed mid-stream: stream continues from the latched tile.

Source files
------------

// File: rtl/act_reg_read_responder_if.sv
// Activation register read/write bus.
// The reader/loader side (master) drives requests and byte writes; the register
// file (slave) drives the streamed bytes, the framing flags and write back-pressure.
interface act_reg_read_responder_if #(
    parameter int NUM_REGS  = 8,
    parameter int ROWS      = 4,
    parameter int ROW_BYTES = 8
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(ROW_BYTES);

    // read request side
    logic          read_req;
    logic [1:0]    read_mode;
    logic [AW-1:0] read_address;

    // streamed response
    logic [7:0]    read_data;
    logic          read_valid;
    logic          row_last;
    logic          reg_last;
    logic          busy;

    // loader byte writes
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_row;
    logic [CW-1:0] wr_col;
    logic [7:0]    wr_data;
    logic          wr_ready;

    modport master (
        output read_req, read_mode, read_address,
        input  read_data, read_valid, row_last, reg_last, busy,
        output wr_en, wr_addr, wr_row, wr_col, wr_data,
        input  wr_ready
    );

    modport slave (
        input  read_req, read_mode, read_address,
        output read_data, read_valid, row_last, reg_last, busy,
        input  wr_en, wr_addr, wr_row, wr_col, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/act_reg_read_responder.sv
// Activation register file with a byte-stream read port.
// Holds NUM_REGS tiles of ROWS x ROW_BYTES bytes in one inferred RAM.
// A read request streams one whole tile (or its upper half, or the tile in
// column-major order) at one byte per cycle with row_last/reg_last framing.
// The pipeline is: counters -> registered RAM read -> registered outputs,
// so the first byte appears two edges after the request is accepted.
// Writes to the tile being streamed are held off through wr_ready.
module act_reg_read_responder #(
    parameter int NUM_REGS  = 8,
    parameter int ROWS      = 4,
    parameter int ROW_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    act_reg_read_responder_if.slave bus
);
    localparam int AW    = $clog2(NUM_REGS);
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(ROW_BYTES);
    localparam int MAW   = AW + RW + CW;
    localparam int DEPTH = NUM_REGS * ROWS * ROW_BYTES;

    localparam logic [RW-1:0] ROW_MAX  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX  = CW'(ROW_BYTES - 1);
    localparam logic [RW-1:0] ROW_HALF = RW'(ROWS / 2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    // control state
    state_t        state_reg;
    logic [AW-1:0] lat_addr_reg;
    logic          col_major_reg;
    logic [RW-1:0] row_cnt_reg;
    logic [CW-1:0] col_cnt_reg;

    // RAM read stage: flags travel alongside the registered RAM output
    logic [7:0]    rd_q_reg;
    logic          s1_valid_reg;
    logic          s1_row_last_reg;
    logic          s1_reg_last_reg;

    // output stage
    logic [7:0]    read_data_reg;
    logic          read_valid_reg;
    logic          row_last_reg;
    logic          reg_last_reg;
    logic          busy_reg;

    // storage
    logic [7:0]    mem [DEPTH];

    // address decode and framing of the byte being issued this cycle
    logic           last_row;
    logic           last_col;
    logic           issue_last;
    logic           issue_row_last;
    logic [MAW-1:0] rd_addr;
    logic [MAW-1:0] wr_full_addr;
    logic           wr_ready_next;
    logic           wr_fire;

    assign last_row       = (row_cnt_reg == ROW_MAX);
    assign last_col       = (col_cnt_reg == COL_MAX);
    // Every ordering finishes on the bottom-right byte of the tile.
    assign issue_last     = last_row && last_col;
    // In column-major mode a "row" of the stream is a tile column.
    assign issue_row_last = col_major_reg ? last_row : last_col;
    assign rd_addr        = {lat_addr_reg, row_cnt_reg, col_cnt_reg};
    assign wr_full_addr   = {bus.wr_addr, bus.wr_row, bus.wr_col};

    // Only the tile currently being streamed is protected from writes.
    assign wr_ready_next  = !(busy_reg && (bus.wr_addr == lat_addr_reg));
    assign wr_fire        = bus.wr_en && wr_ready_next;

    assign bus.wr_ready   = wr_ready_next;
    assign bus.read_data  = read_data_reg;
    assign bus.read_valid = read_valid_reg;
    assign bus.row_last   = row_last_reg;
    assign bus.reg_last   = reg_last_reg;
    assign bus.busy       = busy_reg;

    // Tile RAM: one write port for the loader, one registered read port for the stream.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_full_addr] <= bus.wr_data;
        end
        rd_q_reg <= mem[rd_addr];
    end

    // Read FSM, address counters and registered output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            lat_addr_reg    <= '0;
            col_major_reg   <= 1'b0;
            row_cnt_reg     <= '0;
            col_cnt_reg     <= '0;
            s1_valid_reg    <= 1'b0;
            s1_row_last_reg <= 1'b0;
            s1_reg_last_reg <= 1'b0;
            read_data_reg   <= 8'd0;
            read_valid_reg  <= 1'b0;
            row_last_reg    <= 1'b0;
            reg_last_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            // Output stage follows the RAM stage; data holds when nothing is valid.
            read_valid_reg <= s1_valid_reg;
            row_last_reg   <= s1_valid_reg && s1_row_last_reg;
            reg_last_reg   <= s1_valid_reg && s1_reg_last_reg;
            if (s1_valid_reg) begin
                read_data_reg <= rd_q_reg;
            end
            // busy drops right after the cycle that carried reg_last.
            if (reg_last_reg) begin
                busy_reg <= 1'b0;
            end

            s1_valid_reg    <= 1'b0;
            s1_row_last_reg <= 1'b0;
            s1_reg_last_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.read_req) begin
                        state_reg     <= STREAM;
                        lat_addr_reg  <= bus.read_address;
                        // Mode 11 is handled exactly as mode 00.
                        col_major_reg <= (bus.read_mode == 2'b10);
                        row_cnt_reg   <= (bus.read_mode == 2'b01) ? ROW_HALF : '0;
                        col_cnt_reg   <= '0;
                        busy_reg      <= 1'b1;
                    end
                end

                STREAM: begin
                    s1_valid_reg    <= 1'b1;
                    s1_row_last_reg <= issue_row_last;
                    s1_reg_last_reg <= issue_last;
                    if (col_major_reg) begin
                        row_cnt_reg <= row_cnt_reg + 1'b1;
                        if (last_row) begin
                            col_cnt_reg <= col_cnt_reg + 1'b1;
                        end
                    end else begin
                        col_cnt_reg <= col_cnt_reg + 1'b1;
                        if (last_col) begin
                            row_cnt_reg <= row_cnt_reg + 1'b1;
                        end
                    end
                    if (issue_last) begin
                        state_reg <= WAIT_LOW;
                    end
                end

                WAIT_LOW: begin
                    // Leave only once the request is released and the final
                    // byte is leaving the output stage (or has already left).
                    if (!bus.read_req && (reg_last_reg || !busy_reg)) begin
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_act_reg_read_responder.sv
// Directed bench for act_reg_read_responder: a storage model plus a queue of
// expected stream bytes, checked byte by byte as the stream is produced.
module tb_act_reg_read_responder;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    act_reg_read_responder_if #(.NUM_REGS(8), .ROWS(4), .ROW_BYTES(8)) bus ();

    act_reg_read_responder #(.NUM_REGS(8), .ROWS(4), .ROW_BYTES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;

    logic [7:0] mdl [8][4][8];
    logic [9:0] exp_q [$];   // {data, row_last, reg_last}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input int t, input int r, input int c, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = t[2:0];
        bus.wr_row  = r[1:0];
        bus.wr_col  = c[2:0];
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
        mdl[t][r][c] = d;
    endtask

    // Expected byte order for one transfer, derived from the storage model.
    task automatic build_exp(input int a, input logic [1:0] m);
        if (m == 2'b10) begin
            for (int c = 0; c < 8; c++)
                for (int r = 0; r < 4; r++)
                    exp_q.push_back({mdl[a][r][c], r == 3, (r == 3) && (c == 7)});
        end else begin
            for (int r = (m == 2'b01) ? 2 : 0; r < 4; r++)
                for (int c = 0; c < 8; c++)
                    exp_q.push_back({mdl[a][r][c], c == 7, (r == 3) && (c == 7)});
        end
    endtask

    // One request/stream. abort_at >= 0 resets after that byte index;
    // disturb changes address/mode and issues writes mid-stream.
    task automatic do_stream(input int a, input logic [1:0] m, input bit release_req,
                             input int abort_at, input bit disturb);
        int n;
        logic [9:0] e;
        build_exp(a, m);
        n = exp_q.size();
        bus.read_req     = 1'b1;
        bus.read_address = a[2:0];
        bus.read_mode    = m;
        tick();                                  // acceptance edge
        chk($sformatf("t%0d_m%0d_busy_acc", a, m), bus.busy, 1);
        chk($sformatf("t%0d_m%0d_lat0", a, m), bus.read_valid, 0);
        if (release_req) bus.read_req = 1'b0;
        tick();
        chk($sformatf("t%0d_m%0d_lat1", a, m), bus.read_valid, 0);
        for (int i = 0; i < n; i++) begin
            tick();
            e = exp_q.pop_front();
            chk($sformatf("t%0d_m%0d_b%0d_valid", a, m, i), bus.read_valid, 1);
            chk($sformatf("t%0d_m%0d_b%0d_data", a, m, i), bus.read_data, e[9:2]);
            chk($sformatf("t%0d_m%0d_b%0d_rowlast", a, m, i), bus.row_last, e[1]);
            chk($sformatf("t%0d_m%0d_b%0d_reglast", a, m, i), bus.reg_last, e[0]);
            chk($sformatf("t%0d_m%0d_b%0d_busy", a, m, i), bus.busy, 1);
            if (i == abort_at) begin
                rst = 1'b1;
                bus.read_req = 1'b0;
                tick();
                chk("abort_valid", bus.read_valid, 0);
                chk("abort_busy", bus.busy, 0);
                chk("abort_reglast", bus.reg_last, 0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (disturb && i == 5) begin
                bus.read_address = a[2:0] + 3'd1;
                bus.read_mode    = ~m;
                bus.wr_en   = 1'b1;
                bus.wr_addr = a[2:0];
                bus.wr_row  = 2'd0;
                bus.wr_col  = 3'd0;
                bus.wr_data = 8'hEE;
                #1;
                chk("wr_ready_same_tile", bus.wr_ready, 0);
            end
            if (disturb && i == 6) begin
                bus.wr_addr = 3'd5;
                bus.wr_row  = 2'd1;
                bus.wr_col  = 3'd2;
                bus.wr_data = 8'hA5;
                #1;
                chk("wr_ready_other_tile", bus.wr_ready, 1);
                mdl[5][1][2] = 8'hA5;
            end
            if (disturb && i == 7) bus.wr_en = 1'b0;
        end
        tick();
        chk($sformatf("t%0d_m%0d_end_valid", a, m), bus.read_valid, 0);
        chk($sformatf("t%0d_m%0d_end_busy", a, m), bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.read_req     = 1'b0;
        bus.read_mode    = 2'b00;
        bus.read_address = 3'd0;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = 3'd0;
        bus.wr_row       = 2'd0;
        bus.wr_col       = 3'd0;
        bus.wr_data      = 8'd0;
        tick();
        tick();
        chk("rst_read_data", bus.read_data, 0);
        chk("rst_read_valid", bus.read_valid, 0);
        chk("rst_row_last", bus.row_last, 0);
        chk("rst_reg_last", bus.reg_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        rst = 1'b0;
        tick();

        // tiles 3 and 5 loaded with distinct patterns
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++) begin
                wr_byte(3, r, c, 8'(8 * r + c));
                wr_byte(5, r, c, 8'(8'h80 + 8 * r + c));
            end

        // row-major, column-major, upper half
        do_stream(3, 2'b00, 1'b1, -1, 1'b0);
        do_stream(3, 2'b10, 1'b1, -1, 1'b0);
        do_stream(3, 2'b01, 1'b1, -1, 1'b0);

        // held request yields exactly one stream for 60 cycles
        do_stream(3, 2'b00, 1'b0, -1, 1'b0);
        for (int k = 0; k < 25; k++) begin
            tick();
            chk($sformatf("hold_no_restart_%0d", k), bus.read_valid, 0);
        end
        bus.read_req = 1'b0;
        tick();
        do_stream(3, 2'b00, 1'b1, -1, 1'b0);

        // blocked write to streamed tile, accepted write to tile 5, address change ignored
        do_stream(3, 2'b00, 1'b1, -1, 1'b1);
        do_stream(3, 2'b00, 1'b1, -1, 1'b0);
        do_stream(5, 2'b00, 1'b1, -1, 1'b0);

        // reset at byte 10, then a clean restream with storage intact
        do_stream(3, 2'b00, 1'b1, 10, 1'b0);
        do_stream(3, 2'b00, 1'b1, -1, 1'b0);

        // mode 11 behaves as mode 00
        do_stream(3, 2'b11, 1'b1, -1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
